// File: rtl/cmd_arb_pkg.sv
// cmd_arb_pkg: shared defaults, port index type and output register state for cmd_fifo_arbiter
package cmd_arb_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_NUM_PORT  = 4;
   localparam int DEF_CNT_WIDTH = 16;
   localparam int MAX_NUM_PORT  = 16;
   localparam int PORT_IDX_W    = $clog2(MAX_NUM_PORT);

   typedef logic [PORT_IDX_W-1:0] port_idx_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/cmd_fifo_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder, search starts just after last_grant
module rr_pick
   import cmd_arb_pkg::*;
#(
   parameter int NUM_PORT = DEF_NUM_PORT
) (
   input  logic [NUM_PORT-1:0] req,
   input  port_idx_t           last_grant,
   output logic                gnt_vld,
   output port_idx_t           gnt_idx,
   output logic [NUM_PORT-1:0] gnt_onehot
);

   port_idx_t start;
   int        pidx;

   assign start = (int'(last_grant) >= NUM_PORT - 1) ? '0 : last_grant + 1'b1;

   // walk offsets from farthest to nearest so the nearest requester after start wins
   always_comb begin
      gnt_vld    = 1'b0;
      gnt_idx    = '0;
      gnt_onehot = '0;
      pidx       = 0;
      for (int i = NUM_PORT - 1; i >= 0; i--) begin
         pidx = int'(start) + i;
         if (pidx >= NUM_PORT) pidx = pidx - NUM_PORT;
         if (req[pidx]) begin
            gnt_vld = 1'b1;
            gnt_idx = port_idx_t'(pidx);
         end
      end
      gnt_onehot = gnt_vld ? ({{(NUM_PORT-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   end

endmodule

// File: rtl/cmd_fifo_arbiter.sv
// cmd_fifo_arbiter: round-robin drain of NUM_PORT command FIFOs into one valid/ready output register
// Optional per-port saturating grant counters: define CMD_FIFO_ARBITER_STATS_EN
module cmd_fifo_arbiter
   import cmd_arb_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_PORT  = DEF_NUM_PORT,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NUM_PORT*WIDTH-1:0]   i_fifo_data,
   input  logic [NUM_PORT-1:0]         i_fifo_empty,
   output logic [NUM_PORT-1:0]         o_fifo_rd_en,
   output logic                        o_valid,
   output logic [WIDTH-1:0]            o_data,
   output logic [$clog2(NUM_PORT)-1:0] o_port,
   input  logic                        i_ready
`ifdef CMD_FIFO_ARBITER_STATS_EN
   ,
   output logic [NUM_PORT*CNT_WIDTH-1:0] o_grant_cnt
`endif
);

   if (NUM_PORT < 2 || NUM_PORT > MAX_NUM_PORT || CNT_WIDTH < 1) begin : g_bad_cfg
      $error("cmd_fifo_arbiter: NUM_PORT must be 2..16 and CNT_WIDTH at least 1");
   end

   out_state_t          state_q, state_d;
   port_idx_t           last_grant;
   port_idx_t           gnt_idx;
   logic                gnt_vld;
   logic [NUM_PORT-1:0] gnt_onehot;
   logic                load_ok;
   logic                grant;

   rr_pick #(
      .NUM_PORT(NUM_PORT)
   ) u_rr_pick (
      .req       (~i_fifo_empty),
      .last_grant(last_grant),
      .gnt_vld   (gnt_vld),
      .gnt_idx   (gnt_idx),
      .gnt_onehot(gnt_onehot)
   );

   // the register can take a new command when it is empty or being drained this cycle
   assign load_ok      = !o_valid || i_ready;
   assign grant        = gnt_vld && load_ok && !i_rst;
   assign o_fifo_rd_en = grant ? gnt_onehot : '0;

   // output register occupancy
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_EMPTY;
      else       state_q <= state_d;
   end

   // a grant always refills; otherwise stay full only while the scheduler stalls
   always_comb begin
      state_d = grant ? ST_FULL : (state_q == ST_FULL && !i_ready) ? ST_FULL : ST_EMPTY;
   end

   // occupancy drives the valid flag directly
   always_comb begin
      o_valid = (state_q == ST_FULL);
   end

   // capture the granted head word, its port and advance the rotation pointer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data     <= '0;
         o_port     <= '0;
         last_grant <= port_idx_t'(NUM_PORT - 1);
      end else if (grant) begin
         o_data     <= i_fifo_data[gnt_idx*WIDTH +: WIDTH];
         o_port     <= gnt_idx[$clog2(NUM_PORT)-1:0];
         last_grant <= gnt_idx;
      end
   end

`ifdef CMD_FIFO_ARBITER_STATS_EN
   for (genvar k = 0; k < NUM_PORT; k++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q;
      // saturating count of grants to this port
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst)                               cnt_q <= '0;
         else if (o_fifo_rd_en[k] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
      assign o_grant_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_cmd_fifo_arbiter.sv
// tb_cmd_fifo_arbiter: scoreboard bench with FIFO models and a round-robin reference
module tb_cmd_fifo_arbiter;

   localparam int W = 32;
   localparam int N = 4;
`ifdef CMD_FIFO_ARBITER_STATS_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif

   typedef struct {
      int         port;
      logic [W-1:0] data;
   } ent_t;

   logic           clk = 1'b0;
   logic           i_rst;
   logic [N*W-1:0] i_fifo_data;
   logic [N-1:0]   i_fifo_empty;
   logic [N-1:0]   o_fifo_rd_en;
   logic           o_valid;
   logic [W-1:0]   o_data;
   logic [1:0]     o_port;
   logic           i_ready;
`ifdef CMD_FIFO_ARBITER_STATS_EN
   logic [N*CW-1:0] grant_cnt;
`endif

   logic [W-1:0] q [N][$];
   ent_t         sb[$];
   int           acc_port[$];
   logic [W-1:0] acc_data[$];
   int           last;
   logic         rdy;
   int           n_chk = 0;
   int           n_err = 0;

   cmd_fifo_arbiter #(
      .WIDTH(W),
      .NUM_PORT(N),
      .CNT_WIDTH(CW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_fifo_data (i_fifo_data),
      .i_fifo_empty(i_fifo_empty),
      .o_fifo_rd_en(o_fifo_rd_en),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_port      (o_port),
`ifdef CMD_FIFO_ARBITER_STATS_EN
      .o_grant_cnt (grant_cnt),
`endif
      .i_ready     (i_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int rr(input int lg, input logic [N-1:0] req);
      for (int o = 1; o <= N; o++) begin
         int p = (lg + o) % N;
         if (req[p]) return p;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         i_fifo_empty[k]       = (q[k].size() == 0);
         i_fifo_data[k*W +: W] = (q[k].size() != 0) ? q[k][0] : '0;
      end
      i_ready = rdy;
   endtask

   task automatic model_reset();
      sb.delete();
      last = N - 1;
   endtask

   task automatic step();
      int           g;
      logic [N-1:0] req, on, one;
      ent_t         e;
      drive();
      #1;
      req = ~i_fifo_empty;
      one = 1;
      g   = -1;
      if (!i_rst && (sb.size() == 0 || rdy)) g = rr(last, req);
      on = (g >= 0) ? (one << g) : '0;
      check("rd_en", o_fifo_rd_en, on);
      if (sb.size() != 0) begin
         check("valid", o_valid, 1);
         check("data", o_data, sb[0].data);
         check("port", o_port, sb[0].port);
         if (rdy) begin
            acc_port.push_back(sb[0].port);
            acc_data.push_back(sb[0].data);
            void'(sb.pop_front());
         end
      end else check("valid", o_valid, 0);
      if (g >= 0) begin
         e.port = g;
         e.data = q[g].pop_front();
         sb.push_back(e);
         last = g;
      end
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step();
      end
   endtask

   initial begin
      i_rst        = 1'b1;
      rdy          = 1'b0;
      i_ready      = 1'b0;
      i_fifo_empty = '0;
      i_fifo_data  = '0;
      model_reset();
      @(negedge clk);
      #1;
      check("rst_rd_en", o_fifo_rd_en, 0);
      check("rst_valid", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_port", o_port, 0);
      // idle: everything empty for 10 cycles
      @(negedge clk);
      i_rst = 1'b0;
      rdy   = 1'b1;
      step();
      cycle(9);
      // full rotation with all ports busy
      for (int k = 0; k < N; k++) begin
         q[k].push_back(32'h1000 + k);
         q[k].push_back(32'h2000 + k);
      end
      acc_port.delete();
      acc_data.delete();
      cycle(10);
      check("rot_count", acc_port.size(), 8);
      for (int i = 0; i < acc_port.size(); i++) check("rot_seq", acc_port[i], i % N);
      // single port burst
      q[2].push_back(32'hA);
      q[2].push_back(32'hB);
      q[2].push_back(32'hC);
      acc_data.delete();
      cycle(5);
      check("burst_count", acc_data.size(), 3);
      if (acc_data.size() == 3) begin
         check("burst0", acc_data[0], 32'hA);
         check("burst1", acc_data[1], 32'hB);
         check("burst2", acc_data[2], 32'hC);
      end
      check("burst_idle", o_valid, 0);
      // stall with port 1 held while ports 0 and 3 wait
      rdy = 1'b0;
      q[1].push_back(32'h11);
      cycle(1);
      q[0].push_back(32'h100);
      q[3].push_back(32'h300);
      for (int i = 0; i < 5; i++) begin
         cycle(1);
         check("stall_data", o_data, 32'h11);
         check("stall_port", o_port, 1);
         check("stall_rd_en", o_fifo_rd_en, 0);
      end
      rdy = 1'b1;
      cycle(1);
      check("stall_release", o_fifo_rd_en, 4'b1000);
      cycle(4);
      // asynchronous reset while holding a command
      q[2].push_back(32'h55);
      rdy = 1'b0;
      cycle(2);
      check("pre_rst_valid", o_valid, 1);
      #1;
      i_rst = 1'b1;
      q[0].push_back(32'h66);
      q[2].push_back(32'h77);
      drive();
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_data", o_data, 0);
      check("arst_port", o_port, 0);
      check("arst_rd_en", o_fifo_rd_en, 0);
      model_reset();
      @(negedge clk);
      i_rst = 1'b0;
      rdy   = 1'b1;
      step();
      check("rst_first_gnt", o_fifo_rd_en, 4'b0001);
      cycle(4);
      // random traffic against the reference
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(2) == 0) q[$urandom_range(N-1)].push_back($urandom);
         rdy = ($urandom_range(3) != 0);
         cycle(1);
      end
      rdy = 1'b1;
      cycle(80);
      check("drained", o_valid, 0);
`ifdef CMD_FIFO_ARBITER_STATS_EN
      @(negedge clk);
      i_rst = 1'b1;
      #1;
      check("cnt_rst", grant_cnt, 0);
      model_reset();
      for (int i = 0; i < 20; i++) q[0].push_back(32'h900 + i);
      @(negedge clk);
      i_rst = 1'b0;
      step();
      cycle(23);
      check("cnt_sat", grant_cnt[CW-1:0], 15);
      check("cnt_others", grant_cnt[N*CW-1:CW], 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cmd_fifo_arbiter.md
# cmd_fifo_arbiter

Round-robin drain stage sitting directly downstream of NUM_PORT synchronous command FIFOs, each with a combinational head read. Each cycle the block pops at most one command from a non-empty FIFO and lands it in a single-entry output register. The register presents the command to the DRAM command scheduler over a valid/ready handshake. Full throughput is one command per cycle with fair rotation across ports.

## Interface
Parameters:
- WIDTH, 32, command word width; must equal the upstream FIFO WIDTH.
- NUM_PORT, 4, number of upstream FIFOs; legal range 2..16.
- CNT_WIDTH, 16, grant counter width; used only with the macro defined.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_fifo_data  in  NUM_PORT*WIDTH  FIFO head words; port k occupies [k*WIDTH +: WIDTH].
- i_fifo_empty  in  NUM_PORT  per-FIFO empty flag.
- o_fifo_rd_en  out  NUM_PORT  combinational pop strobe; one-hot or zero.
- o_valid  out  1  output register holds a command.
- o_data  out  WIDTH  registered command.
- o_port  out  $clog2(NUM_PORT)  index of the FIFO that supplied o_data.
- i_ready  in  1  scheduler accepts o_data this cycle.
- o_grant_cnt  out  NUM_PORT*CNT_WIDTH  per-port grant counters; present only with the macro defined.

## Operation
- Output register states:
  - EMPTY: o_valid=0.
  - FULL: o_valid=1.
- load_ok = !o_valid || i_ready. This is the pipelined-ready condition.
- req = ~i_fifo_empty.
- Arbitration when load_ok and req != 0:
  - Search begins at (last_grant+1) mod NUM_PORT, increasing index with wrap.
  - The first requesting port k wins.
- On a grant in cycle t:
  - o_fifo_rd_en[k]=1 in cycle t, combinational from load_ok and req.
  - At edge t+1: o_data <= head of port k, o_port <= k, o_valid <= 1, last_grant <= k.
- Transitions:
  - FULL with i_ready=1 and no grant -> EMPTY.
  - EMPTY with no grant -> stays EMPTY.
  - FULL with i_ready=1 and a grant -> stays FULL with new data (back-to-back).
- last_grant changes only on a grant.
- o_fifo_rd_en is never asserted for a port whose empty flag is 1.
- o_fifo_rd_en is never asserted when load_ok=0.
- i_ready while o_valid=0 is ignored.

## Timing
- Reset values: o_valid=0, o_data=0, o_port=0, last_grant=NUM_PORT-1 (port 0 wins first), all counters 0.
- o_fifo_rd_en is 0 during reset.
- Latency: FIFO becomes non-empty in cycle t with the register EMPTY -> o_valid=1 in cycle t+1.
- Sustained throughput is 1 command per cycle while i_ready=1 and any FIFO is non-empty.
- Stall: o_valid=1 and i_ready=0 -> o_data and o_port hold, and no pop occurs.
- Fairness: with all ports continuously non-empty and i_ready=1, grants run k, k+1, ..., wrapping. Each port is served within NUM_PORT consecutive grants.
- Reset asserted mid-transfer: state clears immediately (asynchronous). The held command is dropped; the upstream FIFO has already popped it.
- Input-to-output path: combinational from i_fifo_empty/i_ready to o_fifo_rd_en only. Everything else is registered.

## Configuration
- Macro: CMD_FIFO_ARBITER_STATS_EN.
- Defined:
  - o_grant_cnt exists.
  - Counter k increments by 1 on each grant to port k.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - Counters are cleared only by i_rst.
- Undefined: port and counters are absent; all other behaviour is identical.

## Structure
- Shared package cmd_arb_pkg holds:
  - Default WIDTH/NUM_PORT/CNT_WIDTH constants.
  - Port index typedef port_idx_t sized by $clog2 of the maximum NUM_PORT.
- Sub-module rr_pick:
  - Purely combinational rotating-priority encoder.
  - Inputs: req[NUM_PORT], last_grant.
  - Outputs: gnt_vld, gnt_idx, gnt_onehot.
- The top module holds the output register, the pointer, and the optional counters.

## Test plan
- Reset, then all FIFOs empty for 10 cycles -> o_valid=0, o_fifo_rd_en=0 throughout.
- All 4 ports non-empty, i_ready=1 for 8 cycles -> o_port sequence 0,1,2,3,0,1,2,3 with o_valid=1 from the second cycle onward; one pop per cycle.
- Only port 2 non-empty with 3 entries (0xA,0xB,0xC), i_ready=1 -> o_data 0xA,0xB,0xC on consecutive cycles, then o_valid=0.
- Register FULL with port 1 data, i_ready=0 for 5 cycles while ports 0/3 non-empty -> o_data/o_port stable, o_fifo_rd_en=0. Release i_ready -> next grant goes to port 3 (after last_grant=1 the search starts at 2).
- i_rst pulsed while o_valid=1 -> o_valid, o_data, o_port drop to 0 without waiting for a clock edge; the first grant after release goes to port 0.
- With CMD_FIFO_ARBITER_STATS_EN defined and CNT_WIDTH=4: 20 grants to port 0 -> o_grant_cnt[0] reads 15, other counters 0.
